// File: rtl/matvec_ctrl_part4.sv
// Sequencing controller for the 8x8 matrix-by-vector datapath.
// It loads W then X from the host stream, runs clear+MAC per row, and hands each row result out.
module matvec_ctrl_part4 #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8,
  parameter int XAW    = $clog2(N_COLS),         // derived, do not override
  parameter int WAW    = $clog2(N_ROWS * N_COLS) // derived, do not override
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      keep_w,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [$clog2(N_ROWS)-1:0] out_row,
  output logic                      out_last,
  output logic [XAW-1:0]            addr_x,
  output logic                      wr_en_x,
  output logic [WAW-1:0]            addr_w,
  output logic                      wr_en_w,
  output logic                      clear_acc,
  output logic                      en_acc,
  output logic                      busy,
  output logic                      done
);
  localparam int RAW = $clog2(N_ROWS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_LOAD_X = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_MAC    = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam logic [WAW-1:0] W_LAST   = WAW'(N_ROWS * N_COLS - 1);
  localparam logic [WAW-1:0] X_LAST   = WAW'(N_COLS - 1);
  localparam logic [XAW-1:0] COL_LAST = XAW'(N_COLS - 1);
  localparam logic [RAW-1:0] ROW_LAST = RAW'(N_ROWS - 1);

  logic [2:0]     state_q, state_d;
  logic [WAW-1:0] cnt_q, cnt_d;
  logic [RAW-1:0] row_q, row_d;
  logic [XAW-1:0] col_q, col_d;
  logic           w_loaded_q, w_loaded_d;
  logic           done_q, done_d;
  logic           last_row;

  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    // NOTE: every _d starts from its _q (or a constant) so no path leaves it unassigned; this keeps the block free of latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    w_loaded_d = w_loaded_q;
    done_d     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      // A partially written W cannot be reused.
      if (state_q == S_LOAD_W) w_loaded_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = (keep_w && w_loaded_q) ? S_LOAD_X : S_LOAD_W;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
        S_LOAD_W: begin
          if (in_valid) begin
            if (cnt_q == W_LAST) begin
              w_loaded_d = 1'b1;
              cnt_d      = '0;
              state_d    = S_LOAD_X;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LOAD_X: begin
          if (in_valid) begin
            if (cnt_q == X_LAST) begin
              cnt_d   = '0;
              row_d   = '0;
              state_d = S_CLEAR;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          col_d   = '0;
          state_d = S_MAC;
        end
        S_MAC: begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_OUT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (last_row) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_CLEAR;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath controls decode from registered state only; write enables also follow in_valid.
  always_comb begin
    in_ready  = 1'b0;
    wr_en_x   = 1'b0;
    wr_en_w   = 1'b0;
    addr_x    = '0;
    addr_w    = '0;
    clear_acc = 1'b0;
    en_acc    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_row   = '0;
    case (state_q)
      S_LOAD_W: begin
        in_ready = 1'b1;
        wr_en_w  = in_valid;
        addr_w   = cnt_q;
      end
      S_LOAD_X: begin
        in_ready = 1'b1;
        wr_en_x  = in_valid;
        addr_x   = cnt_q[XAW-1:0];
      end
      S_CLEAR: clear_acc = 1'b1;
      S_MAC: begin
        en_acc = 1'b1;
        addr_x = col_q;
        addr_w = WAW'(row_q) * WAW'(N_COLS) + WAW'(col_q);
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_row   = row_q;
        out_last  = last_row;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      w_loaded_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      w_loaded_q <= w_loaded_d;
      done_q     <= done_d;
    end
  end

endmodule
